// File: rtl/sync_fifo_ext_pkg.sv
// sync_fifo_ext_pkg
//   Shared sizing helpers and parameter range predicates for sync_fifo_ext.
//   depth_of     : total capacity (RAM + output register) from ADDR_WIDTH
//   level_width  : bits needed to count 0..DEPTH entries
//   af_thresh_ok : almost-full threshold legal range 1..DEPTH
//   ae_thresh_ok : almost-empty threshold legal range 0..DEPTH-1
package sync_fifo_ext_pkg;

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   function automatic int unsigned level_width(input int unsigned addr_width);
      return addr_width + 32'd1;
   endfunction

   function automatic bit af_thresh_ok(input int unsigned af, input int unsigned depth);
      return (af >= 32'd1) && (af <= depth);
   endfunction

   function automatic bit ae_thresh_ok(input int unsigned ae, input int unsigned depth);
      return ae < depth;
   endfunction

endpackage

// File: rtl/sync_fifo_ext_ram.sv
// sync_fifo_ext_ram
//   DATA_WIDTH x DEPTH storage, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//   aclk  : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module sync_fifo_ext_ram
   import sync_fifo_ext_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext
//   Single-clock FIFO with valid/ready on both sides and a registered
//   first-word-fall-through output stage. Capacity DEPTH counts the RAM
//   plus the output register. Reports level and watermark flags.
//   aclk, aresetn        : clock, synchronous active-low reset
//   flush                : synchronous clear of contents (m_data holds)
//   s_data/s_valid/s_ready : write side, transfer = s_valid & s_ready
//   m_data/m_valid/m_ready : read side, transfer = m_valid & m_ready
//   level                : entries held, 0..DEPTH
//   almost_full          : level >= AF_THRESH
//   almost_empty         : level <= AE_THRESH
module sync_fifo_ext
   import sync_fifo_ext_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AF_THRESH  = depth_of(ADDR_WIDTH) - 32'd2,
   parameter int unsigned AE_THRESH  = 1
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic                                flush,
   input  logic [DATA_WIDTH-1:0]               s_data,
   input  logic                                s_valid,
   output logic                                s_ready,
   output logic [DATA_WIDTH-1:0]               m_data,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [level_width(ADDR_WIDTH)-1:0]  level,
   output logic                                almost_full,
   output logic                                almost_empty
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
   localparam int unsigned LVL_W = level_width(ADDR_WIDTH);

   if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_af_range
      $fatal(1, "sync_fifo_ext: AF_THRESH out of range 1..DEPTH");
   end
   if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_ae_range
      $fatal(1, "sync_fifo_ext: AE_THRESH out of range 0..DEPTH-1");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [LVL_W-1:0]      ram_cnt;
   logic                  ram_empty;
   logic                  wr_en;
   logic                  rd_en;
   logic                  load;
   logic                  bypass;
   logic                  ram_we;

   // Handshake side depends only on registered level and reset.
   assign s_ready      = aresetn & (level != LVL_W'(DEPTH));
   assign almost_full  = (level >= LVL_W'(AF_THRESH));
   assign almost_empty = (level <= LVL_W'(AE_THRESH));

   // The output register is always filled whenever the RAM holds data, so
   // the RAM occupancy is simply level minus the register's valid bit.
   always_comb begin
      wr_en     = s_valid & s_ready;
      rd_en     = m_valid & m_ready;
      ram_cnt   = level - LVL_W'(m_valid);
      ram_empty = (ram_cnt == '0);
      load      = ~m_valid | rd_en;
      bypass    = load & ram_empty;
      ram_we    = wr_en & ~bypass & ~flush;
   end

   sync_fifo_ext_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .aclk  (aclk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         m_valid <= 1'b0;
      end else begin
         if (ram_we) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end

         // Refill the head from RAM first; only an empty RAM lets the
         // incoming word go straight into the output register.
         if (load) begin
            if (!ram_empty) begin
               m_data  <= ram_rdata;
               m_valid <= 1'b1;
               rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
            end else if (wr_en) begin
               m_data  <= s_data;
               m_valid <= 1'b1;
            end else begin
               m_valid <= 1'b0;
            end
         end

         if (wr_en && !rd_en) begin
            level <= level + LVL_W'(1);
         end else if (!wr_en && rd_en) begin
            level <= level - LVL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_ext.sv
module tb_sync_fifo_ext;

   localparam int unsigned AW    = 2;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AF    = 2;
   localparam int unsigned AE    = 1;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          flush;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW:0]   level;
   logic          almost_full;
   logic          almost_empty;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] got[$];
   logic          mw, mr;

   always #5 aclk = ~aclk;

   sync_fifo_ext #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .flush        (flush),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Queue model: the head of the queue is what the output must show,
   // the queue size is the level.
   always @(posedge aclk) begin
      if (!aresetn || flush) begin
         q.delete();
      end else begin
         mw = s_valid && (q.size() < DEPTH);
         mr = m_ready && (q.size() > 0);
         if (mr) void'(q.pop_front());
         if (mw) q.push_back(s_data);
      end
   end

   always @(negedge aclk) begin
      if (chk_en) begin
         check("m_valid", 32'(m_valid), 32'(q.size() > 0));
         if (q.size() > 0) check("m_data", 32'(m_data), 32'(q[0]));
         check("level", 32'(level), 32'(q.size()));
         check("s_ready", 32'(s_ready), 32'(aresetn && (q.size() != DEPTH)));
         check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
         check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      flush   = 1'b0;
      s_data  = '0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      step();
      chk_en = 1'b1;
      step();

      // reset state
      check("rst_level", 32'(level), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_ae", 32'(almost_empty), 32'd1);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      aresetn = 1'b1;
      #1;
      check("post_rst_s_ready", 32'(s_ready), 32'd1);

      // single write into empty FIFO, read next cycle
      s_data = 8'hA5; s_valid = 1'b1; m_ready = 1'b1;
      step();
      s_valid = 1'b0;
      check("t1_m_valid", 32'(m_valid), 32'd1);
      check("t1_m_data", 32'(m_data), 32'hA5);
      check("t1_level1", 32'(level), 32'd1);
      step();
      check("t1_level0", 32'(level), 32'd0);
      check("t1_m_valid0", 32'(m_valid), 32'd0);

      // fill to full
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         s_data = 8'(i); s_valid = 1'b1;
         step();
         check("t2_level", 32'(level), 32'(i));
         if (i >= 2) check("t2_af", 32'(almost_full), 32'd1);
      end
      check("t2_s_ready_full", 32'(s_ready), 32'd0);
      s_data = 8'h05;
      step();
      check("t2_level_no_fifth", 32'(level), 32'd4);
      check("t2_head", 32'(m_data), 32'd1);

      // full with write and read presented: only the read happens
      s_data = 8'h55; m_ready = 1'b1;
      step();
      s_valid = 1'b0;
      check("t3_level", 32'(level), 32'd3);
      check("t3_s_ready", 32'(s_ready), 32'd1);
      for (int k = 2; k <= 4; k++) begin
         check("t3_drain", 32'(m_data), 32'(k));
         step();
      end
      check("t3_empty", 32'(level), 32'd0);

      // streaming through the RAM so pointers wrap
      got.delete();
      for (int i = 0; i < 10; i++) begin
         s_data = 8'(8'h10 + i); s_valid = 1'b1; m_ready = (i >= 2);
         if (m_valid && m_ready) got.push_back(m_data);
         step();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (m_valid) got.push_back(m_data);
         step();
      end
      check("t3_stream_count", 32'(got.size()), 32'd10);
      for (int k = 0; k < 10; k++) begin
         if (k < got.size()) check("t3_stream_order", 32'(got[k]), 32'(8'h10 + k));
      end

      // flush with a write presented
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'(8'h31 + i); s_valid = 1'b1;
         step();
      end
      check("t4_level3", 32'(level), 32'd3);
      flush = 1'b1; s_data = 8'h77;
      step();
      flush = 1'b0; s_valid = 1'b0;
      check("t4_level", 32'(level), 32'd0);
      check("t4_m_valid", 32'(m_valid), 32'd0);
      check("t4_ae", 32'(almost_empty), 32'd1);
      check("t4_s_ready", 32'(s_ready), 32'd1);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t4_no_77", 32'(m_valid), 32'd0);
         step();
      end

      // reset mid-stream
      m_ready = 1'b0;
      s_valid = 1'b1; s_data = 8'h41;
      step();
      s_data = 8'h42;
      step();
      check("t5_level2", 32'(level), 32'd2);
      aresetn = 1'b0; s_data = 8'h99;
      #1;
      check("t5_s_ready_rst", 32'(s_ready), 32'd0);
      step();
      aresetn = 1'b1; s_valid = 1'b0;
      check("t5_level", 32'(level), 32'd0);
      check("t5_m_valid", 32'(m_valid), 32'd0);
      check("t5_m_data", 32'(m_data), 32'd0);
      s_valid = 1'b1; s_data = 8'h05;
      step();
      s_valid = 1'b0;
      check("t5_out_valid", 32'(m_valid), 32'd1);
      check("t5_out_data", 32'(m_data), 32'h05);

      // almost_empty boundary
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (level != 0) step();
      end
      check("t6_drained", 32'(level), 32'd0);
      check("t6_ae_l0", 32'(almost_empty), 32'd1);
      m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h61;
      step();
      check("t6_ae_l1", 32'(almost_empty), 32'd1);
      s_data = 8'h62;
      step();
      s_valid = 1'b0;
      check("t6_ae_l2", 32'(almost_empty), 32'd0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("t6_level_back1", 32'(level), 32'd1);
      check("t6_ae_back1", 32'(almost_empty), 32'd1);
      check("t6_head", 32'(m_data), 32'h62);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
